board_ctrl: RTL and testbench

Game-state producer for the 19x19 gomoku display path. Consumes debounced button pulses and a 1 Hz tick. Maintains cursor, stone maps, turn countdown and a sequential five-in-a-row checker. Drives the `map`, `x_index`, `y_index`, `num` and `state` signals that the `graphics` VGA renderer reads.

---
 rtl/board_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_board_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/board_ctrl.sv
// Gomoku 19x19 game-state controller: cursor, stone maps, turn countdown and a
// sequential five-in-a-row checker. Optional turn timer enabled by `TURN_TIMER_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for btn_start; last game's board held for display
// S_PLAY  | accepting cursor moves, placements and 1 Hz ticks
// S_CHECK | probing one neighbour cell per cycle around the last stone
// S_OVER  | game finished; board and winner held until btn_start
module board_ctrl #(
  parameter int TURN_SECONDS = 15
) (
  input  logic         clk,
  input  logic         rst_sys,
  input  logic         btn_up,
  input  logic         btn_down,
  input  logic         btn_left,
  input  logic         btn_right,
  input  logic         btn_place,
  input  logic         btn_start,
  input  logic         tick_1hz,
  output logic [360:0] map,
  output logic [360:0] white_map,
  output logic [4:0]   x_index,
  output logic [4:0]   y_index,
  output logic [4:0]   num,
  output logic [1:0]   state,
  output logic         turn,
  output logic [1:0]   winner
);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_CHECK, S_OVER} st_t;

`ifdef TURN_TIMER_EN
  localparam logic [4:0] NUM_RELOAD = 5'(TURN_SECONDS);
`else
  localparam logic [4:0] NUM_RELOAD = 5'd0;
`endif

  st_t                st, st_nx;
  logic [360:0]       map_nx, white_nx;
  logic [4:0]         x_nx, y_nx, num_nx;
  logic               turn_nx;
  logic [1:0]         winner_nx;
  logic [8:0]         moves, moves_nx;
  logic [4:0]         last_x, last_y, last_x_nx, last_y_nx;
  logic [1:0]         dir, dir_nx, dir_inc;
  logic               side, side_nx;
  logic [2:0]         step, step_nx;
  logic [3:0]         cnt, cnt_nx, cnt_inc;
  logic signed [5:0]  px, py, px_nx, py_nx, lx, ly;
  logic               inb, hit;
  logic [8:0]         probe_idx, cur_idx;

  // Direction table: (+1,0), (0,+1), (+1,+1), (+1,-1)
  function automatic logic signed [5:0] dir_dx(input logic [1:0] d);
    return (d == 2'd1) ? 6'sd0 : 6'sd1;
  endfunction

  function automatic logic signed [5:0] dir_dy(input logic [1:0] d);
    case (d)
      2'd0:    return 6'sd0;
      2'd3:    return -6'sd1;
      default: return 6'sd1;
    endcase
  endfunction

  assign lx        = $signed({1'b0, last_x});
  assign ly        = $signed({1'b0, last_y});
  assign inb       = (px >= 6'sd0) && (px <= 6'sd18) && (py >= 6'sd0) && (py <= 6'sd18);
  assign probe_idx = inb ? (9'(py[4:0]) * 9'd19 + 9'(px[4:0])) : 9'd0;
  assign hit       = inb && map[probe_idx] && (white_map[probe_idx] == turn);
  assign cur_idx   = 9'(y_index) * 9'd19 + 9'(x_index);
  assign cnt_inc   = cnt + 4'd1;
  assign dir_inc   = dir + 2'd1;

  always_comb begin
    case (st)
      S_IDLE:  state = 2'b00;
      S_OVER:  state = 2'b10;
      default: state = 2'b01;
    endcase
  end

  always_ff @(posedge clk or negedge rst_sys) begin
    if (!rst_sys) begin
      st        <= S_IDLE;
      map       <= '0;
      white_map <= '0;
      x_index   <= 5'd9;
      y_index   <= 5'd9;
      num       <= 5'd0;
      turn      <= 1'b0;
      winner    <= 2'b00;
      moves     <= 9'd0;
      last_x    <= 5'd0;
      last_y    <= 5'd0;
      dir       <= 2'd0;
      side      <= 1'b0;
      step      <= 3'd0;
      cnt       <= 4'd0;
      px        <= 6'sd0;
      py        <= 6'sd0;
    end else begin
      st        <= st_nx;
      map       <= map_nx;
      white_map <= white_nx;
      x_index   <= x_nx;
      y_index   <= y_nx;
      num       <= num_nx;
      turn      <= turn_nx;
      winner    <= winner_nx;
      moves     <= moves_nx;
      last_x    <= last_x_nx;
      last_y    <= last_y_nx;
      dir       <= dir_nx;
      side      <= side_nx;
      step      <= step_nx;
      cnt       <= cnt_nx;
      px        <= px_nx;
      py        <= py_nx;
    end
  end

  always_comb begin
    st_nx     = st;
    map_nx    = map;
    white_nx  = white_map;
    x_nx      = x_index;
    y_nx      = y_index;
    num_nx    = num;
    turn_nx   = turn;
    winner_nx = winner;
    moves_nx  = moves;
    last_x_nx = last_x;
    last_y_nx = last_y;
    dir_nx    = dir;
    side_nx   = side;
    step_nx   = step;
    cnt_nx    = cnt;
    px_nx     = px;
    py_nx     = py;

    case (st)
      S_IDLE: begin
        if (btn_start) begin
          st_nx     = S_PLAY;
          map_nx    = '0;
          white_nx  = '0;
          moves_nx  = 9'd0;
          x_nx      = 5'd9;
          y_nx      = 5'd9;
          turn_nx   = 1'b0;
          num_nx    = NUM_RELOAD;
          winner_nx = 2'b00;
        end
      end

      S_PLAY: begin
        if (btn_place && !map[cur_idx]) begin
          map_nx[cur_idx]   = 1'b1;
          white_nx[cur_idx] = turn;
          last_x_nx = x_index;
          last_y_nx = y_index;
          moves_nx  = moves + 9'd1;
          st_nx     = S_CHECK;
          dir_nx    = 2'd0;
          side_nx   = 1'b0;
          step_nx   = 3'd1;
          cnt_nx    = 4'd1;
          px_nx     = $signed({1'b0, x_index}) + dir_dx(2'd0);
          py_nx     = $signed({1'b0, y_index}) + dir_dy(2'd0);
        end else begin
          if (btn_up)
            y_nx = (y_index == 5'd0) ? 5'd18 : y_index - 5'd1;
          else if (btn_down)
            y_nx = (y_index == 5'd18) ? 5'd0 : y_index + 5'd1;
          else if (btn_left)
            x_nx = (x_index == 5'd0) ? 5'd18 : x_index - 5'd1;
          else if (btn_right)
            x_nx = (x_index == 5'd18) ? 5'd0 : x_index + 5'd1;
`ifdef TURN_TIMER_EN
          if (tick_1hz) begin
            if (num == 5'd0) begin
              turn_nx = ~turn;
              num_nx  = NUM_RELOAD;
            end else begin
              num_nx = num - 5'd1;
            end
          end
`endif
        end
      end

      S_CHECK: begin
        if (hit && (cnt_inc >= 4'd5)) begin
          st_nx     = S_OVER;
          winner_nx = turn ? 2'b10 : 2'b01;
        end else if (hit && (step != 3'd4)) begin
          cnt_nx  = cnt_inc;
          step_nx = step + 3'd1;
          px_nx   = side ? px - dir_dx(dir) : px + dir_dx(dir);
          py_nx   = side ? py - dir_dy(dir) : py + dir_dy(dir);
        end else begin
          // Side finished; a hit on the 4th step still counts toward the run
          if (hit)
            cnt_nx = cnt_inc;
          if (!side) begin
            side_nx = 1'b1;
            step_nx = 3'd1;
            px_nx   = lx - dir_dx(dir);
            py_nx   = ly - dir_dy(dir);
          end else if (dir == 2'd3) begin
            if (moves == 9'd361) begin
              st_nx     = S_OVER;
              winner_nx = 2'b11;
            end else begin
              st_nx   = S_PLAY;
              turn_nx = ~turn;
              num_nx  = NUM_RELOAD;
            end
          end else begin
            dir_nx  = dir_inc;
            side_nx = 1'b0;
            step_nx = 3'd1;
            cnt_nx  = 4'd1;
            px_nx   = lx + dir_dx(dir_inc);
            py_nx   = ly + dir_dy(dir_inc);
          end
        end
      end

      S_OVER: begin
        if (btn_start)
          st_nx = S_IDLE;
      end

      default: st_nx = S_IDLE;
    endcase
  end

`ifndef TURN_TIMER_EN
  logic unused_tick;
  assign unused_tick = tick_1hz;
`endif

endmodule

// File: tb/tb_board_ctrl.sv
// Randomised bench for board_ctrl against a board-level gomoku model
// (win found by counting runs on an array, not by replaying the probe walk).
module tb_board_ctrl;
  localparam int TS = 15;
`ifdef TURN_TIMER_EN
  localparam int RELOAD = TS;
  localparam int TIMER  = 1;
`else
  localparam int RELOAD = 0;
  localparam int TIMER  = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_sys;
  logic         btn_up, btn_down, btn_left, btn_right, btn_place, btn_start, tick_1hz;
  logic [360:0] map, white_map;
  logic [4:0]   x_index, y_index, num;
  logic [1:0]   state, winner;
  logic         turn;

  board_ctrl #(.TURN_SECONDS(TS)) dut (
    .clk(clk), .rst_sys(rst_sys),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_place(btn_place), .btn_start(btn_start), .tick_1hz(tick_1hz),
    .map(map), .white_map(white_map), .x_index(x_index), .y_index(y_index),
    .num(num), .state(state), .turn(turn), .winner(winner)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [360:0] m_map, m_white;
  int m_x, m_y, m_turn, m_num, m_state, m_winner, m_moves;

  task automatic check(input string tag, input logic [360:0] got, input logic [360:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int occ(input int x, input int y);
    int i;
    if (x < 0 || x > 18 || y < 0 || y > 18) return 0;
    i = y * 19 + x;
    if (!m_map[i]) return 0;
    return m_white[i] ? 2 : 1;
  endfunction

  function automatic bit wins(input int x, input int y, input int c);
    int dxs[4] = '{1, 0, 1, 1};
    int dys[4] = '{0, 1, 1, -1};
    for (int d = 0; d < 4; d++) begin
      int run = 1;
      for (int si = 0; si < 2; si++) begin
        int s = (si == 0) ? 1 : -1;
        for (int k = 1; k <= 4; k++) begin
          if (occ(x + s * k * dxs[d], y + s * k * dys[d]) != c) break;
          run++;
        end
      end
      if (run >= 5) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_map = '0; m_white = '0; m_x = 9; m_y = 9; m_num = 0;
    m_turn = 0; m_winner = 0; m_state = 0; m_moves = 0;
  endtask

  task automatic compare_all(input string ph);
    check({ph, ":state"},  state,  m_state);
    check({ph, ":x"},      x_index, m_x);
    check({ph, ":y"},      y_index, m_y);
    check({ph, ":turn"},   turn,   m_turn);
    check({ph, ":num"},    num,    m_num);
    check({ph, ":winner"}, winner, m_winner);
    check({ph, ":map"},    map,    m_map);
    check({ph, ":white"},  white_map & map, m_white & m_map);
  endtask

  task automatic wait_check_done();
    int  n = 0;
    logic t0 = turn;
    while (state == 2'b01 && turn == t0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("chk_finished", (state != 2'b01 || turn != t0), 1);
    check("chk_le33", (n <= 33), 1);
  endtask

  task automatic cycle(input bit u, input bit d, input bit l, input bit r,
                       input bit p, input bit s, input bit t);
    bit placed = 0;
    int idx;
    @(negedge clk);
    btn_up = u; btn_down = d; btn_left = l; btn_right = r;
    btn_place = p; btn_start = s; tick_1hz = t;
    @(negedge clk);
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    btn_place = 0; btn_start = 0; tick_1hz = 0;
    case (m_state)
      0: if (s) begin
        m_map = '0; m_white = '0; m_moves = 0; m_x = 9; m_y = 9;
        m_turn = 0; m_num = RELOAD; m_winner = 0; m_state = 1;
      end
      1: begin
        idx = m_y * 19 + m_x;
        if (p && !m_map[idx]) begin
          placed = 1;
          m_map[idx] = 1'b1;
          m_white[idx] = m_turn[0];
          m_moves++;
          if (wins(m_x, m_y, m_turn + 1)) begin
            m_state = 2; m_winner = m_turn + 1;
          end else if (m_moves == 361) begin
            m_state = 2; m_winner = 3;
          end else begin
            m_turn ^= 1; m_num = RELOAD;
          end
        end else begin
          if (u)      m_y = (m_y + 18) % 19;
          else if (d) m_y = (m_y + 1) % 19;
          else if (l) m_x = (m_x + 18) % 19;
          else if (r) m_x = (m_x + 1) % 19;
          if (TIMER == 1 && t) begin
            if (m_num == 0) begin m_turn ^= 1; m_num = RELOAD; end
            else m_num--;
          end
        end
      end
      default: if (s) m_state = 0;
    endcase
    if (placed) begin
      check("place:map",   map,   m_map);
      check("place:white", white_map & map, m_white & m_map);
      check("place:state", state, 1);
      wait_check_done();
    end
    compare_all("cyc");
  endtask

  task automatic goto(input int tx, input int ty);
    for (int i = 0; i < 19 && m_x != tx; i++) cycle(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 19 && m_y != ty; i++) cycle(0, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic place_at(input int px, input int py);
    goto(px, py);
    cycle(0, 0, 0, 0, 1, 0, 0);
  endtask

  task automatic do_reset();
    rst_sys = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    compare_all("reset");
    rst_sys = 1'b1;
  endtask

  initial begin
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    btn_place = 0; btn_start = 0; tick_1hz = 0;
    do_reset();

    // start
    cycle(0, 0, 0, 0, 0, 1, 0);
    check("start_state", state, 2'b01);
    check("start_num", num, RELOAD);

    // wrap-around at (18,0)
    goto(18, 0);
    for (int i = 0; i < 19 && m_y != 0; i++) cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0, 0);
    check("wrap_x", x_index, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    check("wrap_y", y_index, 18);

    // black at (9,9), then white tries the same cell
    place_at(9, 9);
    check("p99_map", map[180], 1);
    check("p99_white", white_map[180], 0);
    check("p99_turn", turn, 1);
    cycle(0, 0, 0, 0, 1, 0, 0);
    check("dup_map", map[180], 1);
    check("dup_white", white_map[180], 0);
    check("dup_turn", turn, 1);

    // black row x=5..9 at y=3, last stone at (7,3)
    place_at(0, 0);  place_at(5, 3);
    place_at(0, 1);  place_at(6, 3);
    place_at(0, 2);  place_at(8, 3);
    place_at(0, 4);  place_at(9, 3);
    place_at(0, 6);  place_at(7, 3);
    check("win_state", state, 2'b10);
    check("win_winner", winner, 2'b01);
    cycle(0, 0, 0, 0, 0, 1, 0);
    check("over_to_idle", state, 2'b00);

    // countdown / timeout
    cycle(0, 0, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 16; k++) cycle(0, 0, 0, 0, 0, 0, 1);
    check("timeout_turn", turn, TIMER);
    check("timeout_num", num, RELOAD);

    // randomised play
    for (int it = 0; it < 400; it++) begin
      if (m_state == 1)
        cycle($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 6) == 0, $urandom_range(0, 15) == 0,
              $urandom_range(0, 3) == 0);
      else
        cycle(0, 0, 0, 0, 0, 1, 0);
    end

    // reset in the middle of CHECK
    do_reset();
    cycle(0, 0, 0, 0, 0, 1, 0);
    @(negedge clk); btn_place = 1;
    @(negedge clk); btn_place = 0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_sys = 1'b0;
    #1;
    check("rst_state", state, 0);
    check("rst_map", map, 0);
    check("rst_white", white_map, 0);
    check("rst_x", x_index, 9);
    check("rst_y", y_index, 9);
    check("rst_num", num, 0);
    check("rst_turn", turn, 0);
    check("rst_winner", winner, 0);
    @(negedge clk);
    rst_sys = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
